// File: rtl/cpu_decode_stage.sv
// Registered RV32I/Zicsr decode stage: classifies the opcode format and
// holds instruction, PC, format and illegal flag behind a valid/ready skid.
package cpu_decode_pkg;

  typedef logic [31:0] isa_instr_t;

  typedef enum logic [2:0] {
    instr_r,
    instr_i,
    instr_iu,
    instr_iucsr,
    instr_s,
    instr_b,
    instr_u,
    instr_j
  } instr_type_e;

  typedef struct packed {
    isa_instr_t  instr;
    logic [31:0] pc;
    instr_type_e itype;
    logic        illegal;
  } dec_slot_t;

  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_imm    = 7'b0010011;
  localparam logic [6:0] op_misc   = 7'b0001111;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_op     = 7'b0110011;
  localparam logic [6:0] op_system = 7'b1110011;

  localparam isa_instr_t nop_instr = 32'h0000_0013;

endpackage

module cpu_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter bit          p_skid     = 1'b1,
  parameter logic [31:0] p_reset_pc = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  isa_instr_t  i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output isa_instr_t  o_instr,
  output logic [31:0] o_pc,
  output instr_type_e o_instr_type,
  output logic        o_illegal
);

  typedef enum logic [1:0] {
    st_empty,
    st_one,
    st_full
  } state_e;

  localparam dec_slot_t rst_slot = '{
    instr:   nop_instr,
    pc:      p_reset_pc,
    itype:   instr_i,
    illegal: 1'b0
  };

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_sys;
  instr_type_e in_type;
  logic        in_ill;
  dec_slot_t   in_slot;
  dec_slot_t   out_q;
  state_e      state;

  assign opc    = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign is_sys = (opc == op_system);

  // Undecodable words still flow downstream, tagged illegal.
  always_comb begin
    in_type = instr_r;
    in_ill  = 1'b0;
    unique case (1'b1)
      (opc == op_lui),
      (opc == op_auipc):    in_type = instr_u;
      (opc == op_jal):      in_type = instr_j;
      (opc == op_jalr),
      (opc == op_load),
      (opc == op_imm),
      (opc == op_misc):     in_type = instr_i;
      (opc == op_branch):   in_type = instr_b;
      (opc == op_store):    in_type = instr_s;
      (opc == op_op):       in_type = instr_r;
      (is_sys && f3 == 3'b000):
                            in_type = instr_i;
      (is_sys && f3 inside {3'b001, 3'b010, 3'b011}):
                            in_type = instr_iu;
      (is_sys && f3 inside {3'b101, 3'b110, 3'b111}):
                            in_type = instr_iucsr;
      default:              in_ill  = 1'b1;
    endcase
  end

  assign in_slot = '{
    instr:   i_instr,
    pc:      i_pc,
    itype:   in_type,
    illegal: in_ill
  };

  generate
    if (p_skid) begin : g_skid
      dec_slot_t skid_q;
      logic      rdy_q;

      assign o_ready = rdy_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state  <= st_empty;
          out_q  <= rst_slot;
          skid_q <= rst_slot;
          rdy_q  <= 1'b1;
        end else if (i_flush) begin
          state <= st_empty;
          rdy_q <= 1'b1;
        end else begin
          unique case (state)
            st_empty: begin
              if (i_valid) begin
                out_q <= in_slot;
                state <= st_one;
              end
            end
            st_one: begin
              if (i_valid && i_ready) begin
                out_q <= in_slot;
              end else if (i_valid) begin
                skid_q <= in_slot;
                state  <= st_full;
                rdy_q  <= 1'b0;
              end else if (i_ready) begin
                state <= st_empty;
              end
            end
            st_full: begin
              // Ready is blocked here, so SKID only ever refills OUT.
              if (i_ready) begin
                out_q <= skid_q;
                state <= st_one;
                rdy_q <= 1'b1;
              end
            end
            default: begin
              state <= st_empty;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_flat
      assign o_ready = (state == st_empty) || i_ready;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state <= st_empty;
          out_q <= rst_slot;
        end else if (i_flush) begin
          state <= st_empty;
        end else if (i_valid && o_ready) begin
          out_q <= in_slot;
          state <= st_one;
        end else if (i_ready) begin
          state <= st_empty;
        end
      end
    end
  endgenerate

  assign o_valid      = (state != st_empty);
  assign o_instr      = out_q.instr;
  assign o_pc         = out_q.pc;
  assign o_instr_type = out_q.itype;
  assign o_illegal    = out_q.illegal;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed bench for cpu_decode_stage, run against a skid instance
// and a single-register instance.
module tb_cpu_decode_stage;
  import cpu_decode_pkg::*;

  localparam logic [31:0] rpc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, flush, valid, rdy_dn;
  logic [31:0] instr, pc;
  logic        skid;

  logic        s_ready, s_valid, s_ill;
  logic [31:0] s_instr, s_pc;
  instr_type_e s_type;
  logic        c_ready, c_valid, c_ill;
  logic [31:0] c_instr, c_pc;
  instr_type_e c_type;

  logic        o_ready, o_valid, o_ill;
  logic [31:0] o_instr, o_pc;
  logic [2:0]  o_type;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_decode_stage #(.p_skid(1'b1), .p_reset_pc(rpc)) u_skid (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(valid), .o_ready(s_ready),
    .i_instr(instr), .i_pc(pc),
    .o_valid(s_valid), .i_ready(rdy_dn),
    .o_instr(s_instr), .o_pc(s_pc),
    .o_instr_type(s_type), .o_illegal(s_ill)
  );

  cpu_decode_stage #(.p_skid(1'b0), .p_reset_pc(rpc)) u_flat (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(valid), .o_ready(c_ready),
    .i_instr(instr), .i_pc(pc),
    .o_valid(c_valid), .i_ready(rdy_dn),
    .o_instr(c_instr), .o_pc(c_pc),
    .o_instr_type(c_type), .o_illegal(c_ill)
  );

  assign o_ready = skid ? s_ready : c_ready;
  assign o_valid = skid ? s_valid : c_valid;
  assign o_ill   = skid ? s_ill   : c_ill;
  assign o_instr = skid ? s_instr : c_instr;
  assign o_pc    = skid ? s_pc    : c_pc;
  assign o_type  = skid ? s_type  : c_type;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b1; valid = 1'b0; rdy_dn = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy_dn = 1'b1;
    instr = 32'h0; pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_valid m%0b got %0b want 0", skid, o_valid); end
    n_vec++; if (o_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready m%0b got %0b want 1", skid, o_ready); end
    n_vec++; if (o_instr !== 32'h0000_0013) begin n_bad++;
      $display("FAIL rst_instr m%0b got %h want 00000013", skid, o_instr); end
    n_vec++; if (o_pc !== rpc) begin n_bad++;
      $display("FAIL rst_pc m%0b got %h want %h", skid, o_pc, rpc); end
    n_vec++; if (o_type !== instr_i) begin n_bad++;
      $display("FAIL rst_type m%0b got %0d want %0d", skid, o_type, instr_i); end
    n_vec++; if (o_ill !== 1'b0) begin n_bad++;
      $display("FAIL rst_ill m%0b got %0b want 0", skid, o_ill); end
  endtask

  task automatic test_stream();
    logic [31:0] w [3];
    instr_type_e t [3];
    w = '{32'h00500093, 32'h002081B3, 32'h000010B7};
    t = '{instr_i, instr_r, instr_u};
    idle();
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; instr = w[k]; pc = 32'(k * 4);
      #1;
      n_vec++; if (o_ready !== 1'b1) begin n_bad++;
        $display("FAIL str_ready%0d m%0b got %0b want 1", k, skid, o_ready); end
      tick();
      n_vec++; if (o_valid !== 1'b1 || o_instr !== w[k]) begin n_bad++;
        $display("FAIL str_word%0d m%0b got %0b/%h want 1/%h",
                 k, skid, o_valid, o_instr, w[k]); end
      n_vec++; if (o_type !== t[k] || o_pc !== 32'(k * 4)) begin n_bad++;
        $display("FAIL str_tag%0d m%0b got %0d/%h want %0d/%h",
                 k, skid, o_type, o_pc, t[k], k * 4); end
    end
    valid = 1'b0;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_bad++;
      $display("FAIL str_drain m%0b got %0b want 0", skid, o_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] w [10];
    instr_type_e t [10];
    w = '{32'h0000006F, 32'h00208463, 32'h00112023, 32'h30529073,
          32'h30545073, 32'h00000073, 32'h00000017, 32'h00002003,
          32'h00008067, 32'h00002073};
    t = '{instr_j, instr_b, instr_s, instr_iu, instr_iucsr, instr_i,
          instr_u, instr_i, instr_i, instr_iu};
    idle();
    for (int k = 0; k < 10; k++) begin
      valid = 1'b1; instr = w[k]; pc = 32'h1000 + 32'(k * 4);
      tick();
      n_vec++; if (o_type !== t[k] || o_ill !== 1'b0) begin n_bad++;
        $display("FAIL dec_%h m%0b got %0d/%0b want %0d/0",
                 w[k], skid, o_type, o_ill, t[k]); end
      n_vec++; if (o_valid !== 1'b1 || o_pc !== 32'h1000 + 32'(k * 4))
      begin n_bad++;
        $display("FAIL dec_pc%0d m%0b got %0b/%h want 1/%h",
                 k, skid, o_valid, o_pc, 32'h1000 + 32'(k * 4)); end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] w [4];
    w = '{32'hFFFFFFFF, 32'h00000000, 32'h00004073, 32'h00500092};
    idle();
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; instr = w[k]; pc = 32'h200;
      tick();
      n_vec++; if (o_ill !== 1'b1 || o_type !== instr_r) begin n_bad++;
        $display("FAIL ill_%h m%0b got %0b/%0d want 1/%0d",
                 w[k], skid, o_ill, o_type, instr_r); end
      n_vec++; if (o_valid !== 1'b1 || o_instr !== w[k]) begin n_bad++;
        $display("FAIL ill_pass%0d m%0b got %0b/%h want 1/%h",
                 k, skid, o_valid, o_instr, w[k]); end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    rdy_dn = 1'b0; valid = 1'b1; instr = 32'h00A00093; pc = 32'h300;
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_instr !== 32'h00A00093) begin n_bad++;
      $display("FAIL bp_a m%0b got %0b/%h want 1/00a00093",
               skid, o_valid, o_instr); end
    instr = 32'h00B00113; pc = 32'h304;
    #1;
    n_vec++; if (o_ready !== skid) begin n_bad++;
      $display("FAIL bp_rdy1 m%0b got %0b want %0b", skid, o_ready, skid); end
    tick();
    n_vec++; if (o_ready !== 1'b0) begin n_bad++;
      $display("FAIL bp_rdy2 m%0b got %0b want 0", skid, o_ready); end
    // Single-register mode keeps B pending upstream.
    valid = !skid;
    tick();
    n_vec++; if (o_instr !== 32'h00A00093 || o_pc !== 32'h300) begin n_bad++;
      $display("FAIL bp_hold m%0b got %h/%h want 00a00093/300",
               skid, o_instr, o_pc); end
    rdy_dn = 1'b1;
    tick();
    valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_instr !== 32'h00B00113 ||
                 o_pc !== 32'h304) begin n_bad++;
      $display("FAIL bp_b m%0b got %0b/%h/%h want 1/00b00113/304",
               skid, o_valid, o_instr, o_pc); end
    n_vec++; if (o_ready !== 1'b1) begin n_bad++;
      $display("FAIL bp_rdy3 m%0b got %0b want 1", skid, o_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_bad++;
      $display("FAIL bp_nodup m%0b got %0b want 0", skid, o_valid); end
  endtask

  task automatic fill();
    idle();
    rdy_dn = 1'b0; valid = 1'b1; instr = 32'h00100093; pc = 32'h400;
    tick();
    instr = 32'h00200113; pc = 32'h404;
    tick();
  endtask

  task automatic test_flush();
    fill();
    flush = 1'b1; valid = 1'b1; instr = 32'h00300193; pc = 32'h408;
    tick();
    flush = 1'b0; valid = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++;
      $display("FAIL fl_state m%0b got v%0b r%0b want v0 r1",
               skid, o_valid, o_ready); end
    rdy_dn = 1'b1;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_bad++;
      $display("FAIL fl_drop m%0b got %0b want 0", skid, o_valid); end
  endtask

  task automatic test_reset_mid();
    fill();
    rst = 1'b1; valid = 1'b1; instr = 32'h00400213; pc = 32'h40C;
    tick();
    rst = 1'b0; valid = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++;
      $display("FAIL rm_state m%0b got v%0b r%0b want v0 r1",
               skid, o_valid, o_ready); end
    n_vec++; if (o_instr !== 32'h13 || o_pc !== rpc ||
                 o_type !== instr_i || o_ill !== 1'b0) begin n_bad++;
      $display("FAIL rm_payload m%0b got %h/%h/%0d/%0b",
               skid, o_instr, o_pc, o_type, o_ill); end
    rdy_dn = 1'b1; valid = 1'b1; instr = 32'h00000517; pc = 32'h500;
    tick();
    valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_instr !== 32'h00000517 ||
                 o_pc !== 32'h500 || o_type !== instr_u) begin n_bad++;
      $display("FAIL rm_resume m%0b got %0b/%h/%h/%0d",
               skid, o_valid, o_instr, o_pc, o_type); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_bad++;
      $display("FAIL rm_drain m%0b got %0b want 0", skid, o_valid); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy_dn = 1'b1;
    instr = 32'h0; pc = 32'h0; skid = 1'b1;
    for (int m = 1; m >= 0; m--) begin
      skid = m[0];
      test_reset();
      test_stream();
      test_decode();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_mid();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
